axi_burst_mem_slave: RTL and testbench
======================================

Name: axi_burst_mem_slave

Overview:
- AXI4 burst slave with a word-addressed memory array.
- It is the responder end of the DMA's AXI master interface: it stands in for DDR in full-system simulation and in on-chip loopback tests.
- It accepts the master's AW/W/B and AR/R traffic, returning write responses and read bursts.
- Read and write channels run independently and concurrently.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- MEM_ADDR_WIDTH, 14, byte-address bits decoded; the array holds 2^(MEM_ADDR_WIDTH-2) words.
- RD_LATENCY, 1, cycles from AR handshake to the first RVALID; legal range 1..15.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  32  write burst start byte address
- S_AXI_AWLEN  in  8  beats minus 1
- S_AXI_AWSIZE  in  3  beat size; 3'b010 is expected
- S_AXI_AWBURST  in  2  00 = FIXED, any other value = INCR
- S_AXI_AWCACHE  in  4  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WLAST  in  1  last write beat
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  00 = OKAY, 10 = SLVERR
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARCACHE  in  32/8/3/2/4  read address channel, same meanings as AW
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RLAST  out  1  last read beat
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All FSMs go to IDLE; beat counters and latency counter clear.
  - AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST are 0; BRESP, RRESP and RDATA are 0.
  - Memory contents are preserved.
  - Reset mid-burst abandons the burst; no response is issued after release.
- Word index = addr[MEM_ADDR_WIDTH-1:2]. Upper address bits are ignored, so the index wraps modulo the array size. Bits [1:0] are ignored.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch index, len, burst and err=(AWSIZE!=3'b010); beat counter=0; go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes the bytes enabled by WSTRB to mem[index]. After each beat, index increments unless burst is FIXED; the index wraps at array end.
  - Burst termination is count-based: the beat with counter==len moves to W_RESP.
  - err is set if WLAST differs from (counter==len) on any accepted beat.
  - W_RESP: BVALID=1, BRESP = err ? 2'b10 : 2'b00. Hold until BREADY, then go to W_IDLE.
  - AWREADY is 0 outside W_IDLE; there is one outstanding write burst.
- Read FSM, R_IDLE -> R_WAIT -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On handshake, latch index, len, burst and err=(ARSIZE!=3'b010); load the latency counter.
  - R_WAIT: the first RVALID rises exactly RD_LATENCY cycles after the AR handshake edge.
  - R_DATA: RVALID=1; RDATA=mem[index]; RRESP = err ? 2'b10 : 2'b00; RLAST=(counter==len).
  - RDATA, RRESP and RLAST are held stable while RVALID&!RREADY.
  - On each RVALID&RREADY: advance index (as for writes) and the counter. After the last beat, RVALID=0 next cycle and the FSM returns to R_IDLE; ARREADY=1 in that cycle.
  - Back-to-back beats are possible: with RREADY held high, one beat transfers per cycle.
- Same-cycle read and write to one word: the read beat returns the pre-write data; the write takes effect at the clock edge.
- AWLEN/ARLEN=255 gives 256 beats. The counter is 8 bits with no overflow past len.
- A burst that crosses the array end wraps to word 0; no error response is raised.

Test Plan:
- Single-beat write: AW addr 0x10, len 0; W 0xDEADBEEF, strb 4'hF, WLAST=1 -> BRESP=00 one cycle after the W beat. Then AR addr 0x10, len 0 -> RDATA=0xDEADBEEF, RLAST=1, RVALID one cycle after AR (RD_LATENCY=1).
- 16-beat INCR write of values 0..15 at 0x100, then 16-beat read with RREADY toggling every other cycle -> data 0..15 in order; RLAST only on beat 15; RDATA stable during stalls.
- Partial strobe: write 0x11223344 with strb 4'b0101 over a word holding 0xAAAAAAAA -> read returns 0xAA22AA44.
- Protocol error: len=3 with WLAST asserted on beat 1 -> all 4 beats are accepted and BRESP=10. A read with ARSIZE=3'b001 -> RRESP=10 on every beat.
- FIXED burst: 4 writes to 0x20 with data 1,2,3,4 -> mem[0x20]=4. Boundary: a burst starting at the last word wraps to word 0.
- Reset asserted mid 8-beat read at beat 3 -> RVALID=0 immediately. After release, ARREADY=1, and previously written data is intact.

Source files
------------

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst responder backed by a word-addressed array; write and read channels
// run as independent FSMs so AW/W/B and AR/R traffic can overlap.
module axi_burst_mem_slave #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  input  logic [31:0]               S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWLEN,
  input  logic [2:0]                S_AXI_AWSIZE,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic [3:0]                S_AXI_AWCACHE,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [31:0]               S_AXI_ARADDR,
  input  logic [7:0]                S_AXI_ARLEN,
  input  logic [2:0]                S_AXI_ARSIZE,
  input  logic [1:0]                S_AXI_ARBURST,
  input  logic [3:0]                S_AXI_ARCACHE,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int IW    = MEM_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;
  localparam int SW    = DATA_WIDTH / 8;
  localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

  // W_IDLE: accept AW | W_DATA: take beats | W_RESP: hold B;  R_IDLE: accept AR | R_WAIT: latency | R_DATA: stream beats
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_e        w_state_q, w_state_d;
  logic [IW-1:0]   widx_q, widx_d, widx_nxt;
  logic [7:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic            wfixed_q, wfixed_d, werr_q, werr_d;
  logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            wlast_exp, mem_we;

  r_state_e        r_state_q, r_state_d;
  logic [IW-1:0]   ridx_q, ridx_d, ridx_nxt;
  logic [7:0]      rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic            rfixed_q, rfixed_d, rerr_q, rerr_d;
  logic [3:0]      lat_q, lat_d;
  logic            arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWCACHE, S_AXI_ARCACHE,
                           S_AXI_AWADDR[31:MEM_ADDR_WIDTH], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[31:MEM_ADDR_WIDTH], S_AXI_ARADDR[1:0]};

  always_comb begin
    w_state_d = w_state_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wfixed_d  = wfixed_q;
    werr_d    = werr_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    wlast_exp = (wcnt_q == wlen_q);
    widx_nxt  = wfixed_q ? widx_q : widx_q + IW'(1);
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (S_AXI_AWVALID && awready_q) begin
          widx_d    = S_AXI_AWADDR[MEM_ADDR_WIDTH-1:2];
          wlen_d    = S_AXI_AWLEN;
          wfixed_d  = (S_AXI_AWBURST == 2'b00);
          werr_d    = (S_AXI_AWSIZE != 3'b010);
          wcnt_d    = 8'd0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          mem_we = 1'b1;
          widx_d = widx_nxt;
          if (S_AXI_WLAST != wlast_exp) werr_d = 1'b1;
          // termination is by beat count; WLAST only feeds the error flag
          if (wlast_exp) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (werr_q || (S_AXI_WLAST != wlast_exp)) ? 2'b10 : 2'b00;
            w_state_d = W_RESP;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      widx_q    <= '0;
      wlen_q    <= 8'd0;
      wcnt_q    <= 8'd0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wfixed_q  <= wfixed_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // No reset on the array: contents must survive ARESETN.
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (S_AXI_WSTRB[b]) mem[widx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rfixed_d  = rfixed_q;
    rerr_d    = rerr_q;
    lat_d     = lat_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    ridx_nxt  = rfixed_q ? ridx_q : ridx_q + IW'(1);
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          ridx_d    = S_AXI_ARADDR[MEM_ADDR_WIDTH-1:2];
          rlen_d    = S_AXI_ARLEN;
          rfixed_d  = (S_AXI_ARBURST == 2'b00);
          rerr_d    = (S_AXI_ARSIZE != 3'b010);
          rcnt_d    = 8'd0;
          lat_d     = LAT_LOAD;
          arready_d = 1'b0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (lat_q == 4'd0) begin
          rvalid_d  = 1'b1;
          rdata_d   = mem[ridx_q];
          rresp_d   = rerr_q ? 2'b10 : 2'b00;
          rlast_d   = (rlen_q == 8'd0);
          r_state_d = R_DATA;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      R_DATA: begin
        // beat data is captured into RDATA so it stays put through stalls
        if (S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            ridx_d  = ridx_nxt;
            rcnt_d  = rcnt_q + 8'd1;
            rdata_d = mem[ridx_nxt];
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
      ridx_q    <= '0;
      rlen_q    <= 8'd0;
      rcnt_q    <= 8'd0;
      rfixed_q  <= 1'b0;
      rerr_q    <= 1'b0;
      lat_q     <= 4'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rfixed_q  <= rfixed_d;
      rerr_q    <= rerr_d;
      lat_q     <= lat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed and randomized bursts against a word-array reference model.
module tb_axi_burst_mem_slave;
  localparam int MAW   = 14;
  localparam int DEPTH = 1 << (MAW - 2);
  localparam int RDL   = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  AWCACHE, ARCACHE, WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_burst_mem_slave #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(MAW), .RD_LATENCY(RDL)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
    .S_AXI_AWBURST(AWBURST), .S_AXI_AWCACHE(AWCACHE),
    .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST),
    .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN), .S_AXI_ARSIZE(ARSIZE),
    .S_AXI_ARBURST(ARBURST), .S_AXI_ARCACHE(ARCACHE),
    .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic write_burst(input logic [31:0] a, input int len, input logic [1:0] bu,
                             input logic [2:0] sz, input int bad);
    int n;
    int idx;
    bit err;
    err = (sz != 3'b010);
    idx = word_of(a);
    AWADDR = a; AWLEN = 8'(len); AWBURST = bu; AWSIZE = sz; AWCACHE = 4'($urandom);
    AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("awready_wait", {31'd0, AWREADY}, 32'd1);
    @(negedge clk);
    AWVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if ($urandom_range(0, 3) == 0) begin WVALID = 1'b0; @(negedge clk); end
      WVALID = 1'b1; WDATA = wd[b]; WSTRB = ws[b];
      WLAST = (bad >= 0) ? (b == bad) : (b == len);
      if (WLAST != (b == len)) err = 1'b1;
      check("wready", {31'd0, WREADY}, 32'd1);
      for (int k = 0; k < 4; k++)
        if (ws[b][k]) ref_mem[idx][8*k +: 8] = wd[b][8*k +: 8];
      if (bu != 2'b00) idx = (idx + 1) % DEPTH;
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check("bvalid", {31'd0, BVALID}, 32'd1);
    check("bresp", {30'd0, BRESP}, err ? 32'd2 : 32'd0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("bvalid_hold", {31'd0, BVALID}, 32'd1);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    check("bvalid_clear", {31'd0, BVALID}, 32'd0);
    check("awready_back", {31'd0, AWREADY}, 32'd1);
  endtask

  // mode: 0 RREADY held high, 1 stall before every even beat, 2 random stalls
  task automatic read_burst(input logic [31:0] a, input int len, input logic [1:0] bu,
                            input logic [2:0] sz, input int mode, input int abort_at);
    int n;
    int idx;
    bit stall;
    logic [31:0] exp_resp;
    exp_resp = (sz != 3'b010) ? 32'd2 : 32'd0;
    idx = word_of(a);
    ARADDR = a; ARLEN = 8'(len); ARBURST = bu; ARSIZE = sz; ARCACHE = 4'($urandom);
    ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("arready_wait", {31'd0, ARREADY}, 32'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    check("rvalid_early", {31'd0, RVALID}, 32'd0);
    n = 0;
    while (RVALID !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("rd_latency", n, RDL);
    for (int b = 0; b <= len; b++) begin
      if (b == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_rvalid", {31'd0, RVALID}, 32'd0);
        check("rst_rlast", {31'd0, RLAST}, 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_arready", {31'd0, ARREADY}, 32'd0);
        RREADY = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("post_rst_rvalid", {31'd0, RVALID}, 32'd0);
          check("post_rst_bvalid", {31'd0, BVALID}, 32'd0);
        end
        check("post_rst_arready", {31'd0, ARREADY}, 32'd1);
        check("post_rst_awready", {31'd0, AWREADY}, 32'd1);
        return;
      end
      check("rvalid", {31'd0, RVALID}, 32'd1);
      check("rdata", RDATA, ref_mem[idx]);
      check("rresp", {30'd0, RRESP}, exp_resp);
      check("rlast", {31'd0, RLAST}, (b == len) ? 32'd1 : 32'd0);
      stall = (mode == 1) ? (b % 2 == 0) : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (stall) begin
        RREADY = 1'b0;
        @(negedge clk);
        check("stall_rvalid", {31'd0, RVALID}, 32'd1);
        check("stall_rdata", RDATA, ref_mem[idx]);
        check("stall_rlast", {31'd0, RLAST}, (b == len) ? 32'd1 : 32'd0);
      end
      RREADY = 1'b1;
      @(negedge clk);
      if (bu != 2'b00) idx = (idx + 1) % DEPTH;
    end
    RREADY = 1'b0;
    check("rvalid_end", {31'd0, RVALID}, 32'd0);
    check("arready_end", {31'd0, ARREADY}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, bad;
    logic [31:0] a;
    logic [1:0] bu;
    logic [2:0] sz;
    rst_n = 1'b1;
    AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01; AWCACHE = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01; ARCACHE = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_awready", {31'd0, AWREADY}, 32'd0);
    check("reset_wready", {31'd0, WREADY}, 32'd0);
    check("reset_bvalid", {31'd0, BVALID}, 32'd0);
    check("reset_bresp", {30'd0, BRESP}, 32'd0);
    check("reset_arready", {31'd0, ARREADY}, 32'd0);
    check("reset_rvalid", {31'd0, RVALID}, 32'd0);
    check("reset_rlast", {31'd0, RLAST}, 32'd0);
    check("reset_rresp", {30'd0, RRESP}, 32'd0);
    check("reset_rdata", RDATA, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_awready", {31'd0, AWREADY}, 32'd1);
    check("release_arready", {31'd0, ARREADY}, 32'd1);

    // fill the whole array with 256-beat bursts so every later read is defined
    for (int blk = 0; blk < DEPTH / 256; blk++) begin
      for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      write_burst(32'(blk * 1024), 255, 2'b01, 3'b010, -1);
    end
    read_burst(32'h400, 255, 2'b01, 3'b010, 2, -1);

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    write_burst(32'h10, 0, 2'b01, 3'b010, -1);
    read_burst(32'h10, 0, 2'b01, 3'b010, 0, -1);

    for (int b = 0; b < 16; b++) begin wd[b] = 32'(b); ws[b] = 4'hF; end
    write_burst(32'h100, 15, 2'b01, 3'b010, -1);
    read_burst(32'h100, 15, 2'b01, 3'b010, 1, -1);

    wd[0] = 32'hAAAAAAAA; ws[0] = 4'hF;
    write_burst(32'h200, 0, 2'b01, 3'b010, -1);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    write_burst(32'h200, 0, 2'b01, 3'b010, -1);
    read_burst(32'h200, 0, 2'b01, 3'b010, 0, -1);

    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    write_burst(32'h300, 3, 2'b01, 3'b010, 1);
    read_burst(32'h300, 3, 2'b01, 3'b010, 0, -1);
    read_burst(32'h300, 3, 2'b01, 3'b001, 2, -1);

    for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
    write_burst(32'h20, 3, 2'b00, 3'b010, -1);
    read_burst(32'h20, 3, 2'b00, 3'b010, 0, -1);

    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    write_burst(32'((DEPTH - 1) * 4), 3, 2'b01, 3'b010, -1);
    read_burst(32'((DEPTH - 1) * 4), 3, 2'b01, 3'b010, 2, -1);
    read_burst(32'h0, 2, 2'b01, 3'b010, 0, -1);

    read_burst(32'h100, 7, 2'b01, 3'b010, 0, 3);
    read_burst(32'h100, 15, 2'b01, 3'b010, 0, -1);

    for (int it = 0; it < 40; it++) begin
      a   = $urandom;
      len = $urandom_range(0, 15);
      bu  = 2'($urandom);
      sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
      bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
      write_burst(a, len, bu, sz, bad);
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
      read_burst(a, len, bu, sz, 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
